cv32e40p_rf_ecc_encoder: RTL and testbench

//  Write-side Hamming SEC encoder for the ECC-protected register file. Takes RF write requests
//  (addr + 32b data) over valid/ready, computes 6 check bits and forms the 38b codeword.

---
 rtl/cv32e40p_rf_ecc_pkg.sv | 40 ++++
 rtl/cv32e40p_rf_ecc_skid.sv | 87 ++++++++
 rtl/cv32e40p_rf_ecc_encoder.sv | 86 ++++++++
 tb/tb_cv32e40p_rf_ecc_encoder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_rf_ecc_pkg.sv
// Shared definitions for the ECC-protected register file: codeword geometry, buffer states
// and the Hamming SEC encode function used by both the write-side encoder and the read-side checker.
package cv32e40p_rf_ecc_pkg;

  localparam int DATA_W = 32;
  localparam int PAR_W  = 6;
  localparam int CW_W   = DATA_W + PAR_W;

  // Check bits live at power-of-two positions p=1,2,4,8,16,32 (cw index p-1).
  localparam logic [CW_W-1:0] PAR_MASK = 38'h00_8000_808B;

  typedef enum logic [1:0] {
    RF_ECC_EMPTY = 2'd0,
    RF_ECC_ONE   = 2'd1,
    RF_ECC_TWO   = 2'd2
  } rf_ecc_state_e;

  function automatic logic [CW_W-1:0] rf_ecc_encode(input logic [DATA_W-1:0] data);
    logic [CW_W-1:0] cw;
    logic            par;
    cw        = '0;
    cw[2]     = data[0];
    cw[6:4]   = data[3:1];
    cw[14:8]  = data[10:4];
    cw[30:16] = data[25:11];
    cw[37:32] = data[31:26];
    // Check slots are still zero here, so summing over every covered position is safe.
    for (int k = 0; k < PAR_W; k++) begin
      par = 1'b0;
      for (int p = 1; p <= CW_W; p++) begin
        if (((p >> k) & 1) != 0) begin
          par = par ^ cw[p-1];
        end
      end
      cw[(1 << k) - 1] = par;
    end
    return cw;
  endfunction

endpackage

// File: rtl/cv32e40p_rf_ecc_skid.sv
// Generic 2-entry valid/ready skid buffer; the output is always the oldest entry and is
// driven straight from a register, and in_ready depends only on the state register.
module cv32e40p_rf_ecc_skid
  import cv32e40p_rf_ecc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  rf_ecc_state_e    state_reg, state_next;
  logic [WIDTH-1:0] main_reg, skid_reg;
  logic             accept, drain;
  logic             load_main_in, load_main_skid, load_skid;

  assign in_ready  = (state_reg != RF_ECC_TWO);
  assign out_valid = (state_reg != RF_ECC_EMPTY);
  assign busy      = out_valid;
  assign out_data  = main_reg;
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RF_ECC_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_reg)
      RF_ECC_EMPTY: begin
        if (accept) begin
          state_next   = RF_ECC_ONE;
          load_main_in = 1'b1;
        end
      end
      RF_ECC_ONE: begin
        if (accept && !drain) begin
          state_next = RF_ECC_TWO;
          load_skid  = 1'b1;
        end else if (!accept && drain) begin
          state_next = RF_ECC_EMPTY;
        end else if (accept && drain) begin
          load_main_in = 1'b1;
        end
      end
      RF_ECC_TWO: begin
        if (drain) begin
          state_next     = RF_ECC_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_next = RF_ECC_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_reg <= '0;
      skid_reg <= '0;
    end else begin
      if (load_main_in) begin
        main_reg <= in_data;
      end else if (load_main_skid) begin
        main_reg <= skid_reg;
      end
      if (load_skid) begin
        skid_reg <= in_data;
      end
    end
  end

endmodule

// File: rtl/cv32e40p_rf_ecc_encoder.sv
// Write-side Hamming SEC encoder feeding the RF write port through a 2-entry skid buffer.
// Optional fault injection is enabled by defining CV32E40P_RF_ECC_INJECT_EN.
module cv32e40p_rf_ecc_encoder
  import cv32e40p_rf_ecc_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_W-1:0]     req_data_i,
  output logic                  wr_valid_o,
  input  logic                  wr_ready_i,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [CW_W-1:0]       wr_cw_o,
  output logic                  busy_o,
`ifdef CV32E40P_RF_ECC_INJECT_EN
  input  logic                  inj_en_i,
  input  logic [CW_W-1:0]       inj_mask_i,
  output logic [CNT_WIDTH-1:0]  inj_cnt_o,
`endif
  output logic [CNT_WIDTH-1:0]  enc_cnt_o
);

  localparam int PAYLOAD_W = ADDR_WIDTH + CW_W;

  logic [CW_W-1:0]      cw_enc, cw_store;
  logic [PAYLOAD_W-1:0] out_payload;
  logic [CNT_WIDTH-1:0] enc_cnt_reg;

  assign cw_enc = rf_ecc_encode(req_data_i);

  always_comb begin
    cw_store = cw_enc;
`ifdef CV32E40P_RF_ECC_INJECT_EN
    if (inj_en_i) begin
      cw_store = cw_enc ^ inj_mask_i;
    end
`endif
  end

  cv32e40p_rf_ecc_skid #(
    .WIDTH(PAYLOAD_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (req_valid_i),
    .in_ready (req_ready_o),
    .in_data  ({req_addr_i, cw_store}),
    .out_valid(wr_valid_o),
    .out_ready(wr_ready_i),
    .out_data (out_payload),
    .busy     (busy_o)
  );

  assign {wr_addr_o, wr_cw_o} = out_payload;

  // Saturating delivery counter: holds at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_cnt_reg <= '0;
    end else if (wr_valid_o && wr_ready_i && (enc_cnt_reg != '1)) begin
      enc_cnt_reg <= enc_cnt_reg + CNT_WIDTH'(1);
    end
  end

  assign enc_cnt_o = enc_cnt_reg;

`ifdef CV32E40P_RF_ECC_INJECT_EN
  logic [CNT_WIDTH-1:0] inj_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_cnt_reg <= '0;
    end else if (req_valid_i && req_ready_o && inj_en_i && (inj_cnt_reg != '1)) begin
      inj_cnt_reg <= inj_cnt_reg + CNT_WIDTH'(1);
    end
  end

  assign inj_cnt_o = inj_cnt_reg;
`endif

endmodule

// File: tb/tb_cv32e40p_rf_ecc_encoder.sv
// Self-checking bench for cv32e40p_rf_ecc_encoder: directed codeword/stall/reset steps plus a
// randomized scoreboard run against a positional Hamming model and read-side checker model.
module tb_cv32e40p_rf_ecc_encoder;

  localparam int AW = 6;
  localparam int CW = 4;  // narrow counter so saturation is reached in a short run

  logic          clk;
  logic          rst_n;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i;
  logic [31:0]   req_data_i;
  logic          wr_valid_o;
  logic          wr_ready_i;
  logic [AW-1:0] wr_addr_o;
  logic [37:0]   wr_cw_o;
  logic          busy_o;
  logic [CW-1:0] enc_cnt_o;
`ifdef CV32E40P_RF_ECC_INJECT_EN
  logic          inj_en_i;
  logic [37:0]   inj_mask_i;
  logic [CW-1:0] inj_cnt_o;
`endif

  int tests  = 0;
  int failed = 0;

  cv32e40p_rf_ecc_encoder #(
    .ADDR_WIDTH(AW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_addr_i (req_addr_i),
    .req_data_i (req_data_i),
    .wr_valid_o (wr_valid_o),
    .wr_ready_i (wr_ready_i),
    .wr_addr_o  (wr_addr_o),
    .wr_cw_o    (wr_cw_o),
    .busy_o     (busy_o),
`ifdef CV32E40P_RF_ECC_INJECT_EN
    .inj_en_i   (inj_en_i),
    .inj_mask_i (inj_mask_i),
    .inj_cnt_o  (inj_cnt_o),
`endif
    .enc_cnt_o  (enc_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: data fills non-power-of-two positions in order; the check vector is the XOR of
  // the positions of all set data bits, and check bit k goes to position 2^k.
  function automatic logic [37:0] ref_encode(input logic [31:0] d);
    logic [37:0] cw;
    logic [5:0]  syn;
    int          di;
    cw  = '0;
    syn = '0;
    di  = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = d[di];
        if (d[di]) syn = syn ^ p[5:0];
        di++;
      end
    end
    for (int k = 0; k < 6; k++) cw[(1 << k) - 1] = syn[k];
    return cw;
  endfunction

  // Read-side checker model: syndrome = XOR of positions of all set bits; flip it if nonzero.
  task automatic ref_check(input logic [37:0] cw_in, output logic [31:0] d, output logic [5:0] syn);
    logic [37:0] cw;
    int          di;
    cw  = cw_in;
    syn = '0;
    for (int p = 1; p <= 38; p++) if (cw[p-1]) syn = syn ^ p[5:0];
    if (syn != 0 && syn <= 6'd38) cw[syn-1] = ~cw[syn-1];
    d  = '0;
    di = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[di] = cw[p-1];
        di++;
      end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send_one(input logic [AW-1:0] a, input logic [31:0] d,
                          input logic [37:0] exp_cw, input string tag);
    req_valid_i = 1'b1;
    req_addr_i  = a;
    req_data_i  = d;
    wr_ready_i  = 1'b1;
    tick();
    req_valid_i = 1'b0;
    check({tag, "_valid"}, 64'(wr_valid_o), 64'd1);
    check({tag, "_cw"}, 64'(wr_cw_o), 64'(exp_cw));
    check({tag, "_addr"}, 64'(wr_addr_o), 64'(a));
    $display("[TB] %s addr=%0h data=%08h cw=%010h", tag, a, d, wr_cw_o);
    tick();
  endtask

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } req_t;

  initial begin
    req_t          q[$];
    int            enc_exp;
    logic          accept, deliver;
    logic [31:0]   cdata;
    logic [5:0]    csyn;
    logic [37:0]   flipped;
    int            pos;
    logic [31:0]   da, db;

    rst_n       = 1'b0;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    req_data_i  = '0;
    wr_ready_i  = 1'b0;
`ifdef CV32E40P_RF_ECC_INJECT_EN
    inj_en_i    = 1'b0;
    inj_mask_i  = '0;
`endif
    tick();
    tick();
    check("rst_wr_valid", 64'(wr_valid_o), 64'd0);
    check("rst_req_ready", 64'(req_ready_o), 64'd1);
    check("rst_wr_addr", 64'(wr_addr_o), 64'd0);
    check("rst_wr_cw", 64'(wr_cw_o), 64'd0);
    check("rst_enc_cnt", 64'(enc_cnt_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    rst_n = 1'b1;
    tick();

    // Known codewords
    send_one(6'h05, 32'h0000_0000, 38'h00_0000_0000, "cw_zero");
    send_one(6'h2A, 32'h0000_0001, 38'h00_0000_0007, "cw_lsb");
    send_one(6'h3F, 32'h8000_0000, 38'h20_8000_000A, "cw_msb");
    check("cnt_after_three", 64'(enc_cnt_o), 64'd3);
    check("empty_after_three", 64'(wr_valid_o), 64'd0);

    // Back-to-back requests into a stalled write port
    do_reset();
    da = $urandom;
    db = $urandom;
    wr_ready_i  = 1'b0;
    req_valid_i = 1'b1;
    req_addr_i  = 6'd1;
    req_data_i  = da;
    tick();
    req_addr_i  = 6'd2;
    req_data_i  = db;
    tick();
    check("stall_ready_lo", 64'(req_ready_o), 64'd0);
    check("stall_cw_a", 64'(wr_cw_o), 64'(ref_encode(da)));
    req_addr_i  = 6'd3;
    req_data_i  = 32'hDEAD_BEEF;
    tick();
    check("stall2_ready_lo", 64'(req_ready_o), 64'd0);
    check("stall2_cw_a", 64'(wr_cw_o), 64'(ref_encode(da)));
    check("stall2_addr_a", 64'(wr_addr_o), 64'd1);
    req_valid_i = 1'b0;
    wr_ready_i  = 1'b1;
    tick();
    $display("[TB] stall_release first addr=%0h cw=%010h", wr_addr_o, wr_cw_o);
    check("rel_cw_b", 64'(wr_cw_o), 64'(ref_encode(db)));
    check("rel_addr_b", 64'(wr_addr_o), 64'd2);
    check("rel_cnt1", 64'(enc_cnt_o), 64'd1);
    tick();
    check("rel_empty", 64'(wr_valid_o), 64'd0);
    check("rel_cnt2", 64'(enc_cnt_o), 64'd2);

    // Async reset while both entries are held
    wr_ready_i  = 1'b0;
    req_valid_i = 1'b1;
    req_data_i  = $urandom;
    tick();
    req_data_i  = $urandom;
    tick();
    req_valid_i = 1'b0;
    check("two_busy", 64'(busy_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_wr_valid", 64'(wr_valid_o), 64'd0);
    check("arst_req_ready", 64'(req_ready_o), 64'd1);
    check("arst_enc_cnt", 64'(enc_cnt_o), 64'd0);
    check("arst_busy", 64'(busy_o), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

`ifdef CV32E40P_RF_ECC_INJECT_EN
    inj_en_i   = 1'b1;
    inj_mask_i = 38'h00_0000_0004;
    send_one(6'h07, 32'h0000_0001, 38'h00_0000_0003, "inj_on");
    check("inj_cnt1", 64'(inj_cnt_o), 64'd1);
    inj_en_i   = 1'b0;
    send_one(6'h08, 32'h0000_0001, 38'h00_0000_0007, "inj_off");
    check("inj_cnt_hold", 64'(inj_cnt_o), 64'd1);
    do_reset();
`endif

    // Randomized traffic against the scoreboard and the checker model
    do_reset();
    enc_exp = 0;
    for (int i = 0; i < 300; i++) begin
      req_valid_i = ($urandom_range(0, 3) != 0);
      req_addr_i  = AW'($urandom);
      req_data_i  = $urandom;
      wr_ready_i  = ($urandom_range(0, 1) != 0);
      @(negedge clk);
      check("rnd_valid", 64'(wr_valid_o), 64'(q.size() != 0));
      check("rnd_ready", 64'(req_ready_o), 64'(q.size() < 2));
      check("rnd_busy", 64'(busy_o), 64'(q.size() != 0));
      check("rnd_cnt", 64'(enc_cnt_o), 64'(enc_exp));
      if (q.size() != 0) begin
        check("rnd_addr", 64'(wr_addr_o), 64'(q[0].addr));
        check("rnd_cw", 64'(wr_cw_o), 64'(ref_encode(q[0].data)));
        pos     = $urandom_range(0, 38);
        flipped = wr_cw_o;
        if (pos < 38) flipped[pos] = ~flipped[pos];
        ref_check(flipped, cdata, csyn);
        check("rnd_corrected", 64'(cdata), 64'(q[0].data));
        if (pos == 38) check("rnd_clean_syn", 64'(csyn), 64'd0);
        else           check("rnd_flip_syn", 64'(csyn), 64'(pos + 1));
      end
      accept  = req_valid_i & req_ready_o;
      deliver = wr_valid_o & wr_ready_i;
      @(posedge clk);
      if (deliver) begin
        $display("[TB] deliver addr=%0h data=%08h", q[0].addr, q[0].data);
        void'(q.pop_front());
        if (enc_exp < (1 << CW) - 1) enc_exp++;
      end
      if (accept) q.push_back('{addr: req_addr_i, data: req_data_i});
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
